// File: rtl/key_arbiter_pkg.sv
// Shared definitions for the key arbiter: key count, index type and LED encoding.
package key_arbiter_pkg;

    localparam int NUM_KEYS = 8;

    typedef logic [2:0] key_idx_t;

    localparam logic [3:0] LED_IDLE = 4'b1111;

    // Active-low LED pattern for an accepted key: key0 -> 1110 ... key7 -> 0111.
    function automatic logic [3:0] led_code(input key_idx_t idx);
        return 4'd14 - {1'b0, idx};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One-bit 2-flop synchronizer plus consecutive-cycle debounce counter.
// press pulses on the edge the debounced level falls, but only once the key has been seen released since reset.
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press,
    output logic held
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          armed_reg;
    logic [1:0]    filled_reg;
    logic [CW-1:0] cnt_reg;
    logic          mismatch;
    logic          change;

    assign mismatch = (sync2_reg != level_reg);
    assign change   = mismatch && (cnt_reg == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            level_reg  <= 1'b1;
            armed_reg  <= 1'b0;
            filled_reg <= 2'b00;
            cnt_reg    <= '0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            filled_reg <= {filled_reg[0], 1'b1};
            // A key held through reset stays disarmed until a real release reaches the synchronizer.
            if (filled_reg[1] && sync2_reg)
                armed_reg <= 1'b1;
            if (change) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else if (mismatch) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = change && !sync2_reg && armed_reg;
    assign held  = !level_reg && armed_reg;

endmodule

// File: rtl/key_arbiter.sv
// Eight debounced active-low keys feeding a round-robin arbiter with a valid/ready event register.
// Optional auto-repeat while a key is held: define KEY_ARBITER_REPEAT_EN.
module key_arbiter
    import key_arbiter_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic                ev_valid,
    input  logic                ev_ready,
    output key_idx_t            ev_code,
    output logic                ev_drop,
    output logic [3:0]          led
);

    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] held_vec;
    logic [NUM_KEYS-1:0] set_vec;
    logic [NUM_KEYS-1:0] pending_reg;
    logic [NUM_KEYS-1:0] pending_next;
    logic [NUM_KEYS-1:0] grant_mask;
    key_idx_t            ptr_reg;
    key_idx_t            winner;
    key_idx_t            idx;
    logic                found;
    logic                load;
    logic                drop_next;
    logic                ev_valid_reg;
    key_idx_t            ev_code_reg;
    logic                ev_drop_reg;
    logic [3:0]          led_reg;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
            key_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                .reset(reset),
                .raw  (key[gi]),
                .press(press_vec[gi]),
                .held (held_vec[gi])
            );
        end
    endgenerate

`ifdef KEY_ARBITER_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [NUM_KEYS-1:0] rep_fire;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_rep
            logic [RW-1:0] rep_cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    rep_cnt_reg <= '0;
                else if (!held_vec[gi] || rep_fire[gi])
                    rep_cnt_reg <= '0;
                else
                    rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end

            assign rep_fire[gi] = held_vec[gi] && (rep_cnt_reg == RW'(REPEAT_CYCLES - 1));
        end
    endgenerate

    assign set_vec = press_vec | rep_fire;
`else
    // Held levels and the repeat period only matter to auto-repeat; fold them into a dead sink.
    logic unused_repeat;
    assign unused_repeat = ^{held_vec, 32'(REPEAT_CYCLES)};
    assign set_vec       = press_vec;
`endif

    // Round-robin search starting at ptr_reg, wrapping 7 -> 0.
    always_comb begin
        found  = 1'b0;
        winner = ptr_reg;
        idx    = ptr_reg;
        for (int k = 0; k < NUM_KEYS; k++) begin
            idx = ptr_reg + key_idx_t'(k);
            if (!found && pending_reg[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign load         = (!ev_valid_reg || ev_ready) && found;
    assign grant_mask   = load ? (NUM_KEYS'(1) << winner) : '0;
    // A press on a key being granted this cycle re-arms its pending bit rather than being lost.
    assign pending_next = (pending_reg & ~grant_mask) | set_vec;
    assign drop_next    = |(set_vec & pending_reg & ~grant_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_reg  <= '0;
            ptr_reg      <= '0;
            ev_valid_reg <= 1'b0;
            ev_code_reg  <= '0;
            ev_drop_reg  <= 1'b0;
            led_reg      <= LED_IDLE;
        end else begin
            pending_reg <= pending_next;
            ev_drop_reg <= drop_next;
            if (ev_valid_reg && ev_ready)
                led_reg <= led_code(ev_code_reg);
            if (load) begin
                ev_valid_reg <= 1'b1;
                ev_code_reg  <= winner;
                ptr_reg      <= winner + 3'd1;
            end else if (ev_ready) begin
                ev_valid_reg <= 1'b0;
            end
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_code  = ev_code_reg;
    assign ev_drop  = ev_drop_reg;
    assign led      = led_reg;

endmodule

// File: doc/key_arbiter.md
KEY_ARBITER -- requirements
Module: key_arbiter

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000: consecutive stable sampled cycles required to accept a key level change.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000: hold time between auto-repeat events (used only with KEY_ARBITER_REPEAT_EN).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key  input  8  raw push buttons, active-low (0 = pressed), asynchronous to clk.
REQ-006 ev_valid  output  1  press event available.
REQ-007 ev_ready  input  1  consumer accepts event when high with ev_valid.
REQ-008 ev_code  output  3  index 0..7 of the pressed key.
REQ-009 ev_drop  output  1  one-cycle pulse: press lost because that key's pending bit was already set.
REQ-010 led  output  4  code of last accepted key, active-low LED bank.

Function
REQ-011 Each key bit SHALL pass a 2-flop synchronizer before debouncing.
REQ-012 Debounced level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle resets the count to 0.
REQ-013 A debounced 1->0 transition on key i SHALL set pending[i] on the same edge the debounced level changes.
REQ-014 If pending[i] is already set when a new press on key i is detected, ev_drop SHALL pulse for one cycle and pending[i] stays set.
REQ-015 Arbiter SHALL be round-robin: search starts at index ptr, wraps 7->0; ptr = 0 after reset; after granting i, ptr = (i+1) mod 8.
REQ-016 Output register is empty when ev_valid = 0; in any cycle it is empty or being accepted (ev_valid & ev_ready) and some pending bit is set, the winner SHALL be loaded: ev_valid = 1, ev_code = winner, pending[winner] cleared, all on the same edge.
REQ-017 Back-to-back events SHALL be possible: acceptance and reload in one cycle, giving one event per cycle throughput.
REQ-018 While ev_valid = 1 and ev_ready = 0, ev_code SHALL hold stable and ev_valid SHALL stay high.
REQ-019 Latency: first ev_valid SHALL assert 1 cycle after pending[i] is set, if the output register is empty.
REQ-020 On acceptance of code c, led SHALL become 4'd14 - c on the next edge (key0->1110 ... key7->0111); otherwise led holds.
REQ-021 Press and grant of the same key in the same cycle: set wins, pending stays set.

Reset
REQ-022 While reset = 0: ev_valid = 0, ev_code = 0, ev_drop = 0, led = 4'b1111, pending = 0, ptr = 0, debounced levels = 8'hFF, counters = 0, synchronizers = 1.
REQ-023 Reset asserted mid-handshake SHALL discard the held event and all pending events; no event SHALL be generated on release for keys already held.

Configuration
REQ-024 Macro KEY_ARBITER_REPEAT_EN defined: a key held continuously (debounced 0) SHALL set pending[i] again every REPEAT_CYCLES after the press, with per-key repeat counters cleared on release.
REQ-025 Macro undefined: exactly one event per debounced press; repeat counters and REPEAT_CYCLES logic absent.

Structure
REQ-026 Shared package key_arbiter_pkg SHALL hold NUM_KEYS = 8, the key-index type (3 bits), LED_IDLE = 4'b1111, and the LED code function 14 - index.
REQ-027 Sub-module key_debounce (synchronizer + counter, one bit, parameter DEB_CYCLES) SHALL be instantiated 8 times.

Verification (bench uses DEB_CYCLES = 4, REPEAT_CYCLES = 20)
REQ-028 key = 8'hFB held 10 cycles, ev_ready = 1 -> single event, ev_code = 2, led = 4'b1100; no further events.
REQ-029 key glitches 8'hFE for 3 cycles then 8'hFF -> no event, led stays 4'b1111.
REQ-030 keys 1, 5, 6 pressed same cycle, ev_ready = 1, ptr = 0 -> events 1, 5, 6 on consecutive cycles, final led = 4'b1000.
REQ-031 ev_ready = 0, key 3 pressed, released, pressed again, then key 3 pressed a third time -> ev_code = 3 held stable, second press sets pending, third press pulses ev_drop; releasing ev_ready yields exactly two events.
REQ-032 Reset asserted while ev_valid = 1 with pending = 8'h81 -> ev_valid = 0, led = 4'b1111 immediately; no events after release.
REQ-033 With KEY_ARBITER_REPEAT_EN, key 7 held 70 cycles, ev_ready = 1 -> 1 press event plus repeats every 20 cycles; without the macro exactly 1 event.
